// File: rtl/iotdf_pkg.sv
// Shared encodings for the IoT data filter: function select codes, FSM states and
// the sample-counter width helper.
package iotdf_pkg;

  localparam logic [2:0] FN_NONE    = 3'd0;
  localparam logic [2:0] FN_MAX     = 3'd1;
  localparam logic [2:0] FN_MIN     = 3'd2;
  localparam logic [2:0] FN_AVG     = 3'd3;
  localparam logic [2:0] FN_EXTRACT = 3'd4;
  localparam logic [2:0] FN_EXCLUDE = 3'd5;
  localparam logic [2:0] FN_PEAKMAX = 3'd6;
  localparam logic [2:0] FN_PEAKMIN = 3'd7;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ACC} st_e;

  function automatic int calc_sw(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/iot_sample_assembler.sv
// Shifts BYTES beats (most significant first) into one sample; o_done pulses
// combinationally with the accepted last beat of a sample.
module iot_sample_assembler #(
  parameter  int BYTE_W = 8,
  parameter  int BYTES  = 16,
  localparam int DATA_W = BYTE_W * BYTES,
  localparam int CW     = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [BYTE_W-1:0] i_beat,
  output logic [DATA_W-1:0] o_sample,
  output logic              o_beat0,
  output logic              o_done
);

  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_sh  <= '0;
    end else if (i_en) begin
      r_sh  <= {r_sh[DATA_W-BYTE_W-1:0], i_beat};
      r_cnt <= (r_cnt == CW'(BYTES-1)) ? '0 : r_cnt + CW'(1);
    end
  end

  assign o_sample = r_sh;
  assign o_beat0  = (r_cnt == '0);
  assign o_done   = i_en && (r_cnt == CW'(BYTES-1));

endmodule

// File: rtl/iot_data_filter_p.sv
// IoT data filter top: FSM, per-round accumulators, peak history and result registers.
// Optional IOTDF_PEAK_CLR_EN adds the peak_clr port for clearing peak history.
module iot_data_filter_p
  import iotdf_pkg::*;
#(
  parameter  int BYTE_W  = 8,
  parameter  int BYTES   = 16,
  parameter  int SAMPLES = 8,
  localparam int DATA_W  = BYTE_W * BYTES,
  localparam int SW      = calc_sw(SAMPLES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_en,
  input  logic [BYTE_W-1:0] iot_in,
  input  logic [2:0]        fn_sel,
  input  logic [DATA_W-1:0] thr_lo,
  input  logic [DATA_W-1:0] thr_hi,
`ifdef IOTDF_PEAK_CLR_EN
  input  logic              peak_clr,
`endif
  output logic              busy,
  output logic              valid,
  output logic [DATA_W-1:0] iot_out
);

  st_e                 r_st;
  logic                r_busy, r_valid, r_peak_vld, r_clr_pend;
  logic [2:0]          r_fn, r_last_fn;
  logic [SW-1:0]       r_smp;
  logic [DATA_W-1:0]   r_lo, r_hi, r_max, r_min, r_peak, r_out;
  logic [DATA_W+SW-1:0] r_sum;

  logic                w_take, w_beat0, w_done, w_last, w_is_peak;
  logic                w_clr_in, w_clr, w_hist_empty, w_res_v;
  logic [DATA_W-1:0]   w_smp, w_max_n, w_min_n, w_ext, w_res;
  logic [DATA_W+SW-1:0] w_sum_n;

  assign w_take = (r_st == ST_LOAD) && in_en;

  iot_sample_assembler #(.BYTE_W(BYTE_W), .BYTES(BYTES)) u_asm (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_take),
    .i_beat   (iot_in),
    .o_sample (w_smp),
    .o_beat0  (w_beat0),
    .o_done   (w_done)
  );

`ifdef IOTDF_PEAK_CLR_EN
  assign w_clr_in = peak_clr;
`else
  assign w_clr_in = 1'b0;
`endif

  // Sample 0 of a round seeds the accumulators instead of folding into stale values.
  assign w_last    = (r_smp == SW'(SAMPLES-1));
  assign w_max_n   = (r_smp == '0 || w_smp > r_max) ? w_smp : r_max;
  assign w_min_n   = (r_smp == '0 || w_smp < r_min) ? w_smp : r_min;
  assign w_sum_n   = (r_smp == '0 ? '0 : r_sum) + (DATA_W+SW)'(w_smp);
  assign w_is_peak = (r_fn == FN_PEAKMAX) || (r_fn == FN_PEAKMIN);
  assign w_ext     = (r_fn == FN_PEAKMAX) ? w_max_n : w_min_n;
  // A clear raised in the same cycle as the round end counts for this round.
  assign w_clr        = w_clr_in || r_clr_pend;
  assign w_hist_empty = !r_peak_vld || w_clr || (r_fn != r_last_fn);

  always_comb begin
    w_res_v = 1'b0;
    w_res   = w_smp;
    case (r_fn)
      FN_MAX:     begin w_res_v = w_last; w_res = w_max_n; end
      FN_MIN:     begin w_res_v = w_last; w_res = w_min_n; end
      FN_AVG:     begin w_res_v = w_last; w_res = w_sum_n[DATA_W+SW-1:SW]; end
      FN_EXTRACT: w_res_v = (r_lo < w_smp) && (w_smp < r_hi);
      FN_EXCLUDE: w_res_v = (w_smp < r_lo) || (w_smp > r_hi);
      FN_PEAKMAX: begin w_res_v = w_last && (w_hist_empty || w_ext > r_peak); w_res = w_ext; end
      FN_PEAKMIN: begin w_res_v = w_last && (w_hist_empty || w_ext < r_peak); w_res = w_ext; end
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st       <= ST_IDLE;
      r_busy     <= 1'b1;
      r_valid    <= 1'b0;
      r_out      <= '0;
      r_fn       <= FN_NONE;
      r_last_fn  <= FN_NONE;
      r_lo       <= '0;
      r_hi       <= '0;
      r_smp      <= '0;
      r_max      <= '0;
      r_min      <= '0;
      r_sum      <= '0;
      r_peak     <= '0;
      r_peak_vld <= 1'b0;
      r_clr_pend <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_clr_in) r_clr_pend <= 1'b1;
      case (r_st)
        ST_IDLE: begin
          r_st   <= ST_LOAD;
          r_busy <= 1'b0;
        end
        ST_LOAD: begin
          if (w_take && w_beat0 && r_smp == '0) begin
            r_fn <= fn_sel;
            r_lo <= thr_lo;
            r_hi <= thr_hi;
          end
          if (w_done) begin
            r_st   <= ST_ACC;
            r_busy <= 1'b1;
          end
        end
        ST_ACC: begin
          r_st   <= ST_LOAD;
          r_busy <= 1'b0;
          r_max  <= w_max_n;
          r_min  <= w_min_n;
          r_sum  <= w_sum_n;
          r_smp  <= w_last ? '0 : r_smp + SW'(1);
          if (w_res_v) begin
            r_valid <= 1'b1;
            r_out   <= w_res;
          end
          if (w_last) begin
            r_last_fn  <= r_fn;
            r_clr_pend <= 1'b0;
            r_peak_vld <= w_is_peak || !w_hist_empty;
            if (w_is_peak && w_res_v) r_peak <= w_ext;
          end
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign valid   = r_valid;
  assign iot_out = r_out;

endmodule

// File: tb/tb_iot_data_filter_p.sv
// Directed plus randomized rounds checked against a round-level reference model.
module tb_iot_data_filter_p;
  localparam int BYTE_W = 8, BYTES = 16, SAMPLES = 8, DATA_W = 128;

  logic              clk = 1'b0, rst = 1'b1, in_en = 1'b0;
  logic [BYTE_W-1:0] iot_in = '0;
  logic [2:0]        fn_sel = '0;
  logic [DATA_W-1:0] thr_lo = '0, thr_hi = '0;
  logic              busy, valid;
  logic [DATA_W-1:0] iot_out;
`ifdef IOTDF_PEAK_CLR_EN
  logic              peak_clr = 1'b0;
`endif

  always #5 clk = ~clk;

  iot_data_filter_p dut (
    .clk(clk), .rst(rst), .in_en(in_en), .iot_in(iot_in), .fn_sel(fn_sel),
    .thr_lo(thr_lo), .thr_hi(thr_hi),
`ifdef IOTDF_PEAK_CLR_EN
    .peak_clr(peak_clr),
`endif
    .busy(busy), .valid(valid), .iot_out(iot_out)
  );

  int npass = 0, ntot = 0, nfail = 0;

  // reference model state
  bit                m_have, m_clr;
  logic [2:0]        m_prev_fn;
  logic [DATA_W-1:0] m_peak, m_out;
  logic [DATA_W-1:0] smp [SAMPLES];

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_have = 0; m_clr = 0; m_prev_fn = 3'd0; m_peak = '0; m_out = '0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (busy && n < 20) begin @(posedge clk); #1; n++; end
    if (busy) chk("ready_timeout", {127'd0, busy}, '0);
  endtask

  task automatic send_sample(input logic [DATA_W-1:0] s, input bit scramble, input bit acc_beat,
                             output logic v, output logic [DATA_W-1:0] d);
    for (int b = 0; b < BYTES; b++) begin
      wait_ready();
      in_en  = 1'b1;
      iot_in = s[DATA_W-1-BYTE_W*b -: BYTE_W];
      @(posedge clk); #1;
      if (b == 0 && scramble) begin
        fn_sel = 3'($urandom);
        thr_lo = {96'd0, 32'($urandom_range(0, 15))};
        thr_hi = {96'd0, 32'($urandom_range(0, 15))};
      end
    end
    chk("busy_in_acc", {127'd0, busy}, 128'd1);
    chk("valid_low_in_acc", {127'd0, valid}, '0);
    if (acc_beat) begin in_en = 1'b1; iot_in = 8'hA5; end
    else in_en = 1'b0;
    @(posedge clk); #1;
    in_en = 1'b0;
    v = valid;
    d = iot_out;
  endtask

  task automatic run_round(input logic [2:0] fn, input logic [DATA_W-1:0] lo, input logic [DATA_W-1:0] hi,
                           input bit scramble, input int acc_k);
    logic [DATA_W+2:0] sum;
    logic [DATA_W+2:0] avg;
    logic [DATA_W-1:0] mx, mn, r, d;
    logic              v;
    bit                ev, fresh;
    sum = '0; mx = smp[0]; mn = smp[0];
    for (int k = 0; k < SAMPLES; k++) begin
      sum = sum + smp[k];
      if (smp[k] > mx) mx = smp[k];
      if (smp[k] < mn) mn = smp[k];
    end
    avg = sum / SAMPLES;
    fn_sel = fn; thr_lo = lo; thr_hi = hi;
    for (int k = 0; k < SAMPLES; k++) begin
      ev = 0; r = m_out;
      case (fn)
        3'd1: if (k == SAMPLES-1) begin ev = 1; r = mx; end
        3'd2: if (k == SAMPLES-1) begin ev = 1; r = mn; end
        3'd3: if (k == SAMPLES-1) begin ev = 1; r = avg[DATA_W-1:0]; end
        3'd4: if (lo < smp[k] && smp[k] < hi) begin ev = 1; r = smp[k]; end
        3'd5: if (smp[k] < lo || smp[k] > hi) begin ev = 1; r = smp[k]; end
        3'd6, 3'd7: if (k == SAMPLES-1) begin
          fresh = !m_have || m_clr || (fn != m_prev_fn);
          if (fresh || (fn == 3'd6 ? mx > m_peak : mn < m_peak)) begin
            ev = 1; r = (fn == 3'd6) ? mx : mn; m_peak = r;
          end
          m_have = 1;
        end
        default: ;
      endcase
      if (k == SAMPLES-1) begin
        if (fn < 3'd6 && m_clr) m_have = 0;
        m_prev_fn = fn; m_clr = 0;
      end
      if (ev) m_out = r;
      send_sample(smp[k], scramble && k == 0, k == acc_k, v, d);
      chk($sformatf("valid fn%0d s%0d", fn, k), {127'd0, v}, {127'd0, ev});
      chk($sformatf("iot_out fn%0d s%0d", fn, k), d, m_out);
    end
  endtask

  task automatic fill8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    smp[0] = 128'(a0); smp[1] = 128'(a1); smp[2] = 128'(a2); smp[3] = 128'(a3);
    smp[4] = 128'(a4); smp[5] = 128'(a5); smp[6] = 128'(a6); smp[7] = 128'(a7);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {127'd0, busy}, 128'd1);
    chk("rst_valid", {127'd0, valid}, '0);
    chk("rst_iot_out", iot_out, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("busy_after_rst", {127'd0, busy}, '0);
    model_reset();
  endtask

  initial begin
    logic [DATA_W-1:0] ones;
    ones = '1;
    model_reset();
    do_reset();

    fill8(3, 9, 1, 9, 2, 0, 5, 4); run_round(3'd1, '0, '0, 0, -1);
    chk("max_is_9", m_out, 128'd9);
    fill8(1, 2, 3, 4, 5, 6, 7, 8); run_round(3'd3, '0, '0, 0, -1);
    chk("avg_is_4", m_out, 128'd4);
    for (int k = 0; k < SAMPLES; k++) smp[k] = ones;
    run_round(3'd3, '0, '0, 0, -1);
    fill8(1, 2, 3, 4, 5, 6, 7, 8); run_round(3'd4, 128'd2, 128'd6, 0, 3);
    run_round(3'd5, 128'd2, 128'd6, 0, -1);
    run_round(3'd4, 128'd6, 128'd6, 0, -1);
    run_round(3'd5, 128'd7, 128'd2, 0, -1);
    run_round(3'd2, '0, '0, 0, 5);
    // PEAKMAX rounds with maxima 5,5,7,3
    fill8(1, 5, 2, 0, 3, 4, 5, 1); run_round(3'd6, '0, '0, 0, -1);
    fill8(5, 0, 0, 0, 0, 0, 0, 0); run_round(3'd6, '0, '0, 0, -1);
    fill8(0, 7, 6, 0, 0, 0, 0, 0); run_round(3'd6, '0, '0, 0, -1);
    chk("peakmax_7", m_out, 128'd7);
    fill8(3, 3, 1, 2, 0, 0, 0, 0); run_round(3'd6, '0, '0, 0, -1);
    fill8(0, 0, 0, 0, 0, 0, 0, 1); run_round(3'd0, '0, '0, 0, -1);

`ifdef IOTDF_PEAK_CLR_EN
    fill8(4, 9, 8, 5, 4, 7, 6, 5); run_round(3'd7, '0, '0, 0, -1);
    peak_clr = 1'b1; @(posedge clk); #1; peak_clr = 1'b0; m_clr = 1;
    fill8(6, 9, 8, 7, 6, 7, 6, 8); run_round(3'd7, '0, '0, 0, -1);
    chk("peakmin_after_clr", m_out, 128'd6);
`endif

    // reset in the middle of a sample
    for (int b = 0; b < 5; b++) begin
      in_en = 1'b1; iot_in = 8'hFF; @(posedge clk); #1;
    end
    in_en = 1'b0;
    do_reset();
    fill8(3, 9, 1, 9, 2, 0, 5, 4); run_round(3'd1, '0, '0, 0, -1);

    for (int r = 0; r < 24; r++) begin
      bit wide;
      wide = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < SAMPLES; k++)
        smp[k] = wide ? {$urandom, $urandom, $urandom, $urandom} : 128'($urandom_range(0, 15));
`ifdef IOTDF_PEAK_CLR_EN
      if ($urandom_range(0, 4) == 0) begin
        peak_clr = 1'b1; @(posedge clk); #1; peak_clr = 1'b0; m_clr = 1;
      end
`endif
      run_round(($urandom_range(0, 2) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom),
                128'($urandom_range(0, 15)), 128'($urandom_range(0, 15)),
                $urandom_range(0, 1) == 1, -1);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", npass, ntot);
    $fatal(1, "watchdog");
  end

endmodule
